// File: rtl/scroll_sequencer_if.sv
// Control and status bundle between the board inputs and the scroll sequencer.
// The master side drives run/direction/speed/step; the sequencer (slave) drives status.
interface scroll_sequencer_if;
  logic       run;
  logic       direction;
  logic [1:0] speed;
  logic       step;
  logic [2:0] position;
  logic       tick;
  logic       busy;
  logic       holding;

  modport master (
    output run, direction, speed, step,
    input  position, tick, busy, holding
  );

  modport slave (
    input  run, direction, speed, step,
    output position, tick, busy, holding
  );
endinterface

// File: rtl/scroll_sequencer.sv
// Rotation-position sequencer for the six-digit scroll display: run/stop, four rates,
// single-step while stopped, and a dwell at the home position after each wrap.
module scroll_sequencer #(
  parameter int unsigned BASE_DIV   = 50_000_000,
  parameter int unsigned HOLD_TICKS = 2
) (
  input logic               clock,
  input logic               reset,
  scroll_sequencer_if.slave bus
);

  localparam int unsigned CntW   = $clog2(BASE_DIV * 8);
  localparam int unsigned HoldW  = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam bit          HoldEn = (HOLD_TICKS != 0);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e           state_q;
  logic [2:0]       pos_q;
  logic             tick_q;
  logic             busy_q;
  logic             holding_q;
  logic [CntW-1:0]  presc_q;
  logic [HoldW-1:0] hold_q;
  logic             step_q;

  logic [31:0]      period_m1;
  logic             strobe;
  logic [CntW-1:0]  presc_inc;
  logic [2:0]       next_pos;
  logic             step_rise;

  always_comb begin
    period_m1 = (32'(BASE_DIV) << bus.speed) - 32'd1;
    // >= so that lowering the speed below the current count fires straight away
    strobe    = (32'(presc_q) >= period_m1);
    presc_inc = presc_q + CntW'(1);
    step_rise = bus.step & ~step_q;
    if (bus.direction) begin
      next_pos = (pos_q == 3'd0) ? 3'd5 : pos_q - 3'd1;
    end else begin
      next_pos = (pos_q >= 3'd5) ? 3'd0 : pos_q + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pos_q     <= 3'd0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      holding_q <= 1'b0;
      presc_q   <= '0;
      hold_q    <= '0;
      step_q    <= 1'b0;
    end else begin
      // Edge history tracks step in every state so a stop never replays an old edge
      step_q <= bus.step;
      tick_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          presc_q <= '0;
          hold_q  <= '0;
          if (bus.run) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
          end else if (step_rise) begin
            pos_q  <= next_pos;
            tick_q <= 1'b1;
          end
        end
        StRun: begin
          if (!bus.run) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            presc_q <= '0;
          end else begin
            presc_q <= strobe ? '0 : presc_inc;
            if (strobe) begin
              pos_q  <= next_pos;
              tick_q <= 1'b1;
              if (HoldEn && next_pos == 3'd0) begin
                state_q   <= StHold;
                holding_q <= 1'b1;
                hold_q    <= '0;
              end
            end
          end
        end
        StHold: begin
          if (!bus.run) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            holding_q <= 1'b0;
            presc_q   <= '0;
            hold_q    <= '0;
          end else begin
            presc_q <= strobe ? '0 : presc_inc;
            if (strobe) begin
              // Leave on the strobe after HOLD_TICKS full periods: HOLD_TICKS+1 in total
              if (hold_q == HoldW'(HOLD_TICKS)) begin
                state_q   <= StRun;
                holding_q <= 1'b0;
                pos_q     <= next_pos;
                tick_q    <= 1'b1;
              end else begin
                hold_q <= hold_q + HoldW'(1);
              end
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          holding_q <= 1'b0;
          presc_q   <= '0;
          hold_q    <= '0;
        end
      endcase
    end
  end

  assign bus.position = pos_q;
  assign bus.tick     = tick_q;
  assign bus.busy     = busy_q;
  assign bus.holding  = holding_q;

endmodule

// File: doc/scroll_sequencer.md
# scroll_sequencer

Sequencing controller for the six-digit HELLO scroll display. It generates the 3-bit rotation position (0..5) that drives the existing rotate/decoder stage, and replaces the free-running timer. It adds run/stop control, four selectable scroll rates, single-step from a pushbutton, and a programmable dwell when the message returns to its home position. Sits between the board inputs (SW/KEY) and the rotation datapath.

## Interface
- BASE_DIV, default 50_000_000: clock cycles per position step at speed 0 (1 Hz at 50 MHz).
- HOLD_TICKS, default 2: prescaler periods to dwell at home (position 0) after wrapping in RUN. 0 disables dwell.

- clock  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = scroll, 0 = stop (position frozen).
- direction  in  1  0 = increment position, 1 = decrement.
- speed  in  2  step period = BASE_DIV << speed cycles (x1, x2, x4, x8).
- step  in  1  active-high level (already debounced); a rising edge advances one position while stopped.
- position  out  3  current rotation index, always 0..5; registered.
- tick  out  1  one-cycle pulse, coincident with every position change.
- busy  out  1  1 when state is RUN or HOLD.
- holding  out  1  1 when state is HOLD.

## Operation
- States: IDLE, RUN, HOLD. Reset -> IDLE.
- Reset values: position=0, tick=0, busy=0, holding=0, prescaler=0, hold counter=0, step history register=0.
- Prescaler: counts clock cycles in RUN and HOLD only. Terminal when count >= (BASE_DIV << speed) - 1. On terminal, count returns to 0 and an internal period strobe fires. Width holds BASE_DIV*8-1. Because the comparison is >=, a speed decrease below the current count fires the strobe on the next cycle.
- Advance rule: direction=0 gives 5->0, otherwise +1. direction=1 gives 0->5, otherwise -1. direction is sampled at the advance cycle; a change never resets the prescaler.
- IDLE:
  - run=1 -> RUN next cycle with the prescaler at 0.
  - A step rising edge (step=1 and previous sample=0) advances position and pulses tick.
  - step held high produces exactly one advance.
  - If run and a step edge occur in the same cycle, run wins and the step is ignored.
- RUN:
  - Each period strobe advances position and pulses tick.
  - If the advance lands on position 0 and HOLD_TICKS>0, go to HOLD with the hold counter at 0.
  - run=0 -> IDLE next cycle, prescaler cleared, position retained.
- HOLD:
  - position is frozen and tick stays 0.
  - Each period strobe increments the hold counter.
  - When the counter reaches HOLD_TICKS, go to RUN, and that same strobe advances position (0->1 or 0->5) with a tick.
  - run=0 -> IDLE and the hold counter is cleared. A later run restarts in RUN with no dwell.
- step is ignored in RUN and HOLD. The edge history still updates, so an edge spanning a stop is not replayed.
- Reset asserted in any state returns all registers to their reset values on the next edge.

## Timing
- All outputs are registered. position and tick change on the same clock edge.
- run rises at edge k in IDLE: RUN from k+1, first tick at edge k+1+(BASE_DIV<<speed).
- Consecutive ticks in RUN are exactly BASE_DIV<<speed cycles apart.
- Dwell at home: (HOLD_TICKS+1) periods between the tick into 0 and the tick out of 0.
- step edge sampled at edge k: position updates and tick pulses at edge k+1. One-cycle latency.
- run falls at edge k: no tick from edge k+1 onward, and busy=0 at k+1.

## Test plan
Bench parameters: BASE_DIV=4, HOLD_TICKS=2.

- Reset mid-RUN at position 3 -> next cycle position=0, tick=0, busy=0, holding=0.
- run=1, direction=0, speed=0 -> ticks every 4 cycles, positions 1,2,3,4,5,0. holding=1 for 12 cycles, then position 1. tick never asserts during HOLD.
- From IDLE at position 0: direction=1, run=1 -> positions 5,4,3. Flipping direction to 0 at position 3 makes the next tick give position 4 with no period disturbance.
- speed=3 in RUN -> ticks 32 cycles apart. Switching speed 3->0 when the prescaler count is 20 -> tick on the next cycle, then every 4 cycles.
- IDLE with step held high for 10 cycles -> exactly one tick, position 0->1. Pulsing step 3 times with direction=1 from position 1 -> positions 0,5,4. step pulses during RUN -> no extra ticks.
- run dropped in HOLD after 1 dwell period -> IDLE, position stays 0. run raised again -> first tick after 4 cycles gives position 1 with no dwell.
